booth_mul_sched: RTL and testbench

Sequencing and arbitration controller for a shared iterative radix-2 Booth multiplier datapath. It accepts signed multiply requests from two requesters, grants one at a time round-robin, and runs the Booth add/subtract/shift recurrence one step per clock. It returns the signed product with the requester ID over a valid/ready response channel. It sits between the ALU issue logic and the single multiplier resource.

---
 rtl/booth_mul_sched.sv | 159 +++++++++++++++
 tb/tb_booth_mul_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin front end and sequencer for one shared radix-2
// Booth multiplier; one Booth step per clock, product returned with requester ID.
// Latency: WIDTH cycles from the accept edge to rsp_valid. Backpressure: rsp_ready
// low parks the FSM in DONE with outputs frozen; no request is granted while busy.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   reqN_valid/reqN_ready          request handshake for requester N (N = 0, 1)
//   reqN_m, reqN_q                 signed multiplicand / multiplier, sampled at accept
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_product            requester ID and signed 2*WIDTH-bit product
//   busy                           high whenever an operation is in flight

module booth_mul_sched #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_m,
    input  logic [WIDTH-1:0]   req0_q,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_m,
    input  logic [WIDTH-1:0]   req1_q,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH:0]   a_q, a_d;          // one guard bit so subtracting the most negative M cannot overflow
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             grant0, grant1;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;

    // Lone valid always wins; on a tie the requester not served last wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
        grant1 = req1_valid & (~req0_valid | ~last_q);
    end

    assign req0_ready  = (state_q == S_IDLE) & ~rst & grant0;
    assign req1_ready  = (state_q == S_IDLE) & ~rst & grant1;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign busy        = busy_q;
    // The guard bit of A is dropped: the product always fits in 2*WIDTH bits.
    assign rsp_product = {a_q[WIDTH-1:0], q_q};

    // Booth recoding of the pair {Q[0], q_1}.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        a_d         = a_q;
        q_d         = q_q;
        q1_d        = q1_q;
        m_d         = m_q;
        count_d     = count_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    m_d     = req1_ready ? req1_m : req0_m;
                    q_d     = req1_ready ? req1_q : req0_q;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    id_d    = req1_ready;
                    last_d  = req1_ready;
                    busy_d  = 1'b1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // Arithmetic shift right of {A, Q, q_1} after the add/subtract.
                a_d     = {sum[WIDTH], sum[WIDTH:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            m_q         <= '0;
            count_q     <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            a_q         <= a_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            m_q         <= m_d;
            count_q     <= count_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Testbench for booth_mul_sched: scenario tasks with inline checks plus a
// scoreboard that records the expected product at every accepted request and
// compares it at every response handshake.

module tb_booth_mul_sched;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic           rsp_valid, rsp_id, busy;
    logic           rsp_ready = 1'b0;
    logic [2*W-1:0] rsp_product;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t sb[$];

    booth_mul_sched #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_m      (req0_m),
        .req0_q      (req0_q),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_m      (req1_m),
        .req1_q      (req1_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Scoreboard: push at request handshake, pop at response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            n_checks++;
            if (busy && (req0_ready || req1_ready)) begin
                n_fail++;
                $display("FAIL grant_while_busy: ready0=%0b ready1=%0b, required 0 0", req0_ready, req1_ready);
            end
            if (req0_valid && req0_ready) sb.push_back({1'b0, ref_mul(req0_m, req0_q)});
            if (req1_valid && req1_ready) sb.push_back({1'b1, ref_mul(req1_m, req1_q)});
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: got id=%0d prod=%h, required no response", rsp_id, rsp_product);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_product} !== e) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got id=%0d prod=%h, required id=%0d prod=%h",
                                 rsp_id, rsp_product, e.id, e.prod);
                    end
                end
            end
        end
    end

    // Drives one request, waits for the accept, then for rsp_valid; returns the
    // observed product/id and the number of edges from accept to rsp_valid.
    task automatic run_op(input bit id, input logic [W-1:0] m, input logic [W-1:0] q,
                          input bit scramble, output logic [2*W-1:0] prod,
                          output logic pid, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_m = m; req1_q = q; end
        else    begin req0_valid = 1'b1; req0_m = m; req0_q = q; end
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) ok = 1'b0;
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (scramble) begin
            if (id) begin req1_m = ~m; req1_q = q + 8'd3; end
            else    begin req0_m = ~m; req0_q = q + 8'd3; end
        end
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = n;
        if (n >= 40) ok = 1'b0;
        prod = rsp_product;
        pid  = rsp_id;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 60);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid_busy: got %b, required 00", {rsp_valid, busy});
        end
        n_checks++;
        if ({rsp_id, rsp_product} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got id=%0d prod=%h, required 0 0000", rsp_id, rsp_product);
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single;
        logic [2*W-1:0] p; logic pid; int lat; bit ok;
        rsp_ready = 1'b1;
        run_op(1'b0, 8'd3, 8'd5, 1'b0, p, pid, lat, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: got ok=%0b, required 1", ok); end
        n_checks++;
        if (lat != W) begin n_fail++; $display("FAIL single_latency: got %0d, required %0d", lat, W); end
        n_checks++;
        if (p !== 16'h000F || pid !== 1'b0) begin
            n_fail++; $display("FAIL single_result: got id=%0d prod=%h, required 0 000f", pid, p);
        end
    endtask

    task automatic test_products;
        logic           tid[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0]   tm[5]  = '{8'hF9, 8'h80, 8'h80, 8'h7F, 8'h00};
        logic [W-1:0]   tq[5]  = '{8'h06, 8'h80, 8'h7F, 8'h7F, 8'hFB};
        logic [2*W-1:0] te[5]  = '{16'hFFD6, 16'h4000, 16'hC080, 16'h3F01, 16'h0000};
        logic [2*W-1:0] p; logic pid; int lat; bit ok;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_op(tid[i], tm[i], tq[i], 1'b0, p, pid, lat, ok);
            n_checks++;
            if (!ok || p !== te[i] || pid !== tid[i]) begin
                n_fail++;
                $display("FAIL product_%0d: got ok=%0b id=%0d prod=%h, required ok=1 id=%0d prod=%h",
                         i, ok, pid, p, tid[i], te[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int  gid[4]; int gt[4]; int ng; int cyc; bit ok;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        rsp_ready = 1'b1;
        req0_m = 8'd5;  req0_q = 8'hFD; req0_valid = 1'b1;
        req1_m = 8'hF7; req1_q = 8'd11; req1_valid = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 200) begin
            @(negedge clk);
            if (req0_ready) begin gid[ng] = 0; gt[ng] = cyc; ng++; end
            else if (req1_ready) begin gid[ng] = 1; gt[ng] = cyc; ng++; end
            cyc++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (ng != 4) begin n_fail++; $display("FAIL alt_grant_count: got %0d, required 4", ng); end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (gid[i] != (i % 2)) begin
                n_fail++; $display("FAIL alt_grant_%0d: got req%0d, required req%0d", i, gid[i], i % 2);
            end
            if (i > 0) begin
                n_checks++;
                if (gt[i] - gt[i-1] != W + 2) begin
                    n_fail++; $display("FAIL alt_interval_%0d: got %0d, required %0d", i, gt[i] - gt[i-1], W + 2);
                end
            end
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL alt_drain: got busy stuck, required idle"); end
    endtask

    task automatic test_backpressure;
        logic [2*W-1:0] p; logic pid; int lat; bit ok; bit stable;
        rsp_ready = 1'b0;
        run_op(1'b0, 8'hFE, 8'd100, 1'b0, p, pid, lat, ok);
        req1_m = 8'd9; req1_q = 8'd10; req1_valid = 1'b1;
        n_checks++;
        if (!ok || p !== 16'hFF38 || pid !== 1'b0) begin
            n_fail++; $display("FAIL bp_result: got ok=%0b id=%0d prod=%h, required ok=1 id=0 prod=ff38", ok, pid, p);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (!rsp_valid || rsp_product !== p || rsp_id !== pid || req0_ready || req1_ready)
                stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++; $display("FAIL bp_hold: got valid=%0b prod=%h id=%0d, required 1 %h %0d with no ready",
                               rsp_valid, rsp_product, rsp_id, p, pid);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got valid=%0b busy=%0b, required 0 0", rsp_valid, busy);
        end
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_next_accept: got req1_ready=%0b, required 1", req1_ready);
        end
        @(posedge clk); #1; req1_valid = 1'b0;
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got busy stuck, required idle"); end
    endtask

    task automatic test_operand_change;
        logic [2*W-1:0] p; logic pid; int lat; bit ok;
        rsp_ready = 1'b1;
        run_op(1'b0, 8'd12, 8'hF5, 1'b1, p, pid, lat, ok);
        n_checks++;
        if (!ok || p !== 16'hFF7C) begin
            n_fail++; $display("FAIL operand_capture: got ok=%0b prod=%h, required ok=1 prod=ff7c", ok, p);
        end
    endtask

    task automatic test_reset_abort;
        int n; bit saw; bit ok;
        for (int sc = 0; sc < 2; sc++) begin
            if (sc == 0) begin
                rsp_ready = 1'b1;
                @(posedge clk); #1; req0_valid = 1'b1; req0_m = 8'd7; req0_q = 8'd9;
                n = 0;
                @(negedge clk);
                while (!req0_ready && n < 40) begin @(negedge clk); n++; end
                @(posedge clk); #1; req0_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1; rst = 1'b1;
            end else begin
                rsp_ready = 1'b0;
                @(posedge clk); #1; req1_valid = 1'b1; req1_m = 8'hFB; req1_q = 8'hFB;
                n = 0;
                @(negedge clk);
                while (!req1_ready && n < 40) begin @(negedge clk); n++; end
                @(posedge clk); #1; req1_valid = 1'b0;
                n = 0;
                @(negedge clk);
                while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
                @(posedge clk); #1; rst = 1'b1;
            end
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, busy, rsp_id} !== 3'b000 || rsp_product !== '0) begin
                n_fail++;
                $display("FAIL abort_%0d_state: got valid=%0b busy=%0b id=%0d prod=%h, required all 0",
                         sc, rsp_valid, busy, rsp_id, rsp_product);
            end
            rsp_ready = 1'b1;
            saw = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (rsp_valid) saw = 1'b1;
            end
            n_checks++;
            if (saw) begin n_fail++; $display("FAIL abort_%0d_no_rsp: got rsp_valid=1, required 0", sc); end
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_m = 8'd2;  req0_q = 8'd3;
            req1_valid = 1'b1; req1_m = 8'd4;  req1_q = 8'd5;
            @(negedge clk);
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b10) begin
                n_fail++; $display("FAIL abort_%0d_tie: got ready=%b, required 10", sc, {req0_ready, req1_ready});
            end
            @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
            drain(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL abort_%0d_drain: got busy stuck, required idle", sc); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_products();
        test_back_to_back();
        test_backpressure();
        test_operand_change();
        test_reset_abort();
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
